// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_subtractor
// Description : Multi-cycle WIDTH-bit subtractor, D = A - B - bin, one
//               4-bit nibble per clock, least significant nibble first.
//               Each nibble is A_nib + ~B_nib + carry (inverted-operand add).
//               Start/ready/done handshake; result and flags are registered
//               and held until the next operation completes.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             V,
    output logic             Z
);

    // WIDTH must be a multiple of 4 and at least 4.
    localparam int NNIB = WIDTH / 4;
    localparam int KW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;        // minuend, shifted down one nibble per RUN cycle
    logic [WIDTH-1:0] b_q, b_d;        // subtrahend, shifted the same way
    logic             a_msb_q, a_msb_d; // sign bits kept aside for the overflow flag
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] work_q, work_d;  // partial difference, filled from the top
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;

    logic [4:0]       w_sum;
    logic [WIDTH-1:0] w_work_ins;
    logic             w_last;

    // Nibble slice: the current nibble always sits in the low 4 bits of the
    // shifted operands; the new result nibble enters the working register at
    // the top so that after NNIB steps nibble 0 lands at the bottom.
    always_comb begin
        w_sum      = {1'b0, a_q[3:0]} + {1'b0, ~b_q[3:0]} + {4'b0000, carry_q};
        w_work_ins = (work_q >> 4) | (WIDTH'(w_sum[3:0]) << (WIDTH - 4));
        w_last     = (k_q == KW'(NNIB - 1));
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        work_d  = work_q;
        carry_d = carry_q;
        k_d     = k_q;
        d_d     = d_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    a_msb_d = A[MSB];
                    b_msb_d = B[MSB];
                    carry_d = ~bin;
                    work_d  = '0;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                work_d  = w_work_ins;
                carry_d = w_sum[4];
                k_d     = k_q + 1'b1;
                if (w_last) begin
                    // Publish the complete result only once every nibble is in.
                    k_d     = '0;
                    d_d     = w_work_ins;
                    bout_d  = ~w_sum[4];
                    z_d     = (w_work_ins == '0);
                    v_d     = (a_msb_q != b_msb_q) && (w_work_ins[MSB] != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            work_q  <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
        end
    end

    // Handshake decoded from the registered state; results straight from flops.
    always_comb begin
        ready = (state_q == S_IDLE);
        done  = (state_q == S_DONE);
        D     = d_q;
        bout  = bout_q;
        V     = v_q;
        Z     = z_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_subtractor
// Description : Scoreboard bench for nibble_serial_subtractor at WIDTH=16 and
//               WIDTH=4. Accepted operations push a reference result; a
//               negedge monitor tracks handshake timing and held outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_subtractor;

    logic        Clk = 1'b0;
    logic        Reset;

    logic        start16, bin16, rdy16, done16, bout16, v16, z16;
    logic [15:0] a16, b16, d16;
    logic        start4, bin4, rdy4, done4, bout4, v4, z4;
    logic [3:0]  a4, b4, d4;

    typedef struct {
        logic [15:0] d;
        logic        bout;
        logic        v;
        logic        z;
    } res_t;

    res_t q16[$];
    res_t q4[$];
    res_t held16 = '{d: 16'h0, bout: 1'b0, v: 1'b0, z: 1'b0};
    res_t held4  = '{d: 16'h0, bout: 1'b0, v: 1'b0, z: 1'b0};

    int n_tests = 0;
    int n_fail  = 0;
    int busy16  = 0;
    int busy4   = 0;
    int acc4    = 0;
    logic rst_applied = 1'b0;

    nibble_serial_subtractor #(.WIDTH(16)) u_dut16 (
        .Clk(Clk), .Reset(Reset), .start(start16), .A(a16), .B(b16), .bin(bin16),
        .ready(rdy16), .done(done16), .D(d16), .bout(bout16), .V(v16), .Z(z16)
    );

    nibble_serial_subtractor #(.WIDTH(4)) u_dut4 (
        .Clk(Clk), .Reset(Reset), .start(start4), .A(a4), .B(b4), .bin(bin4),
        .ready(rdy4), .done(done4), .D(d4), .bout(bout4), .V(v4), .Z(z4)
    );

    always #5 Clk = ~Clk;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input int w, input int a, input int b, input int bi);
        res_t r;
        int m, diff, sa, sb, sd;
        m    = 1 << w;
        diff = a - b - bi;
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        sd   = sa - sb - bi;
        r.d    = 16'((diff + m) % m);
        r.bout = (diff < 0);
        r.v    = (sd < -(m / 2)) || (sd >= m / 2);
        r.z    = (r.d == 16'h0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: handshake timing, scoreboard pops, held-output checks.
    always @(negedge Clk) begin
        if (rst_applied) begin
            held16 = '{d: 16'h0, bout: 1'b0, v: 1'b0, z: 1'b0};
            held4  = '{d: 16'h0, bout: 1'b0, v: 1'b0, z: 1'b0};
        end
        if (busy16 > 0) busy16--;
        if (busy4 > 0)  busy4--;
        chk("ready16", {31'b0, rdy16}, {31'b0, busy16 == 0});
        chk("done16",  {31'b0, done16}, {31'b0, busy16 == 1});
        chk("ready4",  {31'b0, rdy4},  {31'b0, busy4 == 0});
        chk("done4",   {31'b0, done4}, {31'b0, busy4 == 1});
        if (done16) begin
            if (q16.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done16_unexpected: got done with empty scoreboard at %0t", $time);
            end else held16 = q16.pop_front();
        end
        if (done4) begin
            if (q4.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL done4_unexpected: got done with empty scoreboard at %0t", $time);
            end else held4 = q4.pop_front();
        end
        chk("D16",    {16'b0, d16},   {16'b0, held16.d});
        chk("bout16", {31'b0, bout16}, {31'b0, held16.bout});
        chk("V16",    {31'b0, v16},    {31'b0, held16.v});
        chk("Z16",    {31'b0, z16},    {31'b0, held16.z});
        chk("D4",     {28'b0, d4},     {16'b0, held4.d});
        chk("bout4",  {31'b0, bout4},  {31'b0, held4.bout});
        chk("V4",     {31'b0, v4},     {31'b0, held4.v});
        chk("Z4",     {31'b0, z4},     {31'b0, held4.z});
        rst_applied = Reset;
        if (Reset) begin
            q16.delete();
            q4.delete();
            busy16 = 0;
            busy4  = 0;
        end else begin
            if (start16 && rdy16) begin
                q16.push_back(model(16, int'(a16), int'(b16), int'(bin16)));
                busy16 = 6;
            end
            if (start4 && rdy4) begin
                q4.push_back(model(4, int'(a4), int'(b4), int'(bin4)));
                busy4 = 3;
                acc4++;
            end
        end
    end

    // Issue one 16-bit operation and let it drain.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
        @(posedge Clk); #1;
        a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (rdy16) break;
        end
        @(posedge Clk); #1;
        start16 = 1'b0;
        repeat (7) @(posedge Clk);
    endtask

    logic [15:0] ta [7] = '{16'h1234, 16'h0000, 16'h8000, 16'h5555, 16'h5555, 16'h7FFF, 16'h8000};
    logic [15:0] tb [7] = '{16'h0034, 16'h0001, 16'h0001, 16'h5555, 16'h5555, 16'hFFFF, 16'h0000};
    logic        tbi[7] = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1};

    initial begin
        Reset = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        start4  = 1'b0; a4  = '0; b4  = '0; bin4  = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;

        for (int i = 0; i < 7; i++) op16(ta[i], tb[i], tbi[i]);

        // A start pulse during RUN with other operands must be ignored.
        @(posedge Clk); #1;
        a16 = 16'hABCD; b16 = 16'h0123; bin16 = 1'b0; start16 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (rdy16) break;
        end
        @(posedge Clk); #1;
        start16 = 1'b0;
        @(posedge Clk); #1;
        a16 = 16'h1111; b16 = 16'h2222; bin16 = 1'b1; start16 = 1'b1;
        @(posedge Clk); #1;
        start16 = 1'b0;
        repeat (8) @(posedge Clk);

        // Reset during the second RUN cycle aborts the operation.
        @(posedge Clk); #1;
        a16 = 16'h4321; b16 = 16'h1234; bin16 = 1'b0; start16 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (rdy16) break;
        end
        @(posedge Clk); #1;
        start16 = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        op16(16'h9000, 16'h0FFF, 1'b1);

        // Back-to-back 16-bit operations with operands changing every cycle.
        @(posedge Clk); #1;
        start16 = 1'b1;
        repeat (300) begin
            @(posedge Clk); #1;
            a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom);
        end
        start16 = 1'b0;
        repeat (10) @(posedge Clk);

        // WIDTH=4 random run against the reference model.
        #1 start4 = 1'b1;
        for (int g = 0; g < 40000 && acc4 < 10000; g++) begin
            @(posedge Clk); #1;
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
        end
        start4 = 1'b0;
        repeat (10) @(posedge Clk);

        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("acc4_count", {31'b0, acc4 >= 10000}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
